// File: rtl/sprite_row_streamer.sv
// Writable WIDTH x DEPTH sprite mask that streams a wrapping row range over valid/ready.
// Optional horizontal mirror: define SPRITE_HMIRROR_EN.
module sprite_row_streamer #(
    parameter int WIDTH = 51,
    parameter int DEPTH = 60,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic [AW-1:0]    first_row,
    input  logic [AW:0]      row_count,
    input  logic             flip_v,
    input  logic             mirror_h,
    output logic             busy,
    output logic             reject,
    output logic             done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AW-1:0]    out_row,
    output logic             out_last
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [AW:0]      remain_q, remain_d;
    logic             flip_q, flip_d;
    logic             busy_q, busy_d;
    logic             reject_q, reject_d;
    logic             done_q, done_d;
    logic             rd_valid_q, rd_valid_d;
    logic [AW-1:0]    rd_row_q, rd_row_d;
    logic             rd_last_q, rd_last_d;
    logic             b0_valid_q, b0_valid_d, b1_valid_q, b1_valid_d;
    logic [WIDTH-1:0] b0_data_q, b0_data_d, b1_data_q, b1_data_d;
    logic [AW-1:0]    b0_row_q, b0_row_d, b1_row_q, b1_row_d;
    logic             b0_last_q, b0_last_d, b1_last_q, b1_last_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] push_data;
    logic             pop;
    logic [2:0]       occ_after;
    logic             space;
    logic [AW+1:0]    end_sum;
    logic [AW-1:0]    end_addr;
    logic             illegal;

    // NOTE: the mask RAM has no reset so it maps onto block RAM; rst_n leaves contents intact.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH)))
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data_q <= mem[rd_addr];
    end

`ifdef SPRITE_HMIRROR_EN
    logic mirror_q, mirror_d;

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
        return r;
    endfunction

    always_comb push_data = mirror_q ? bit_rev(rd_data_q) : rd_data_q;

    always_comb begin
        mirror_d = mirror_q;
        if (state_q == IDLE && start && !illegal && row_count != '0)
            mirror_d = mirror_h;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mirror_q <= 1'b0;
        else        mirror_q <= mirror_d;
    end
`else
    logic unused_mirror_h;
    assign unused_mirror_h = mirror_h;
    assign push_data       = rd_data_q;
`endif

    // Reads are throttled so an in-flight read always has a buffer slot when it lands.
    assign pop       = b0_valid_q & out_ready;
    assign occ_after = 3'(b0_valid_q) + 3'(b1_valid_q) + 3'(rd_valid_q) - 3'(pop);
    assign space     = occ_after < 3'd2;

    assign illegal  = ({1'b0, first_row} >= (AW+1)'(DEPTH)) || (row_count > (AW+1)'(DEPTH));
    assign end_sum  = (AW+2)'(first_row) + (AW+2)'(row_count) - (AW+2)'(1);
    assign end_addr = (end_sum >= (AW+2)'(DEPTH)) ? AW'(end_sum - (AW+2)'(DEPTH)) : AW'(end_sum);

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        b0_valid_d = b0_valid_q;  b0_data_d = b0_data_q;  b0_row_d = b0_row_q;  b0_last_d = b0_last_q;
        b1_valid_d = b1_valid_q;  b1_data_d = b1_data_q;  b1_row_d = b1_row_q;  b1_last_d = b1_last_q;
        if (pop) begin
            b0_valid_d = b1_valid_q;  b0_data_d = b1_data_q;  b0_row_d = b1_row_q;  b0_last_d = b1_last_q;
            b1_valid_d = 1'b0;
        end
        if (rd_valid_q) begin
            if (!b0_valid_d) begin
                b0_valid_d = 1'b1;  b0_data_d = push_data;  b0_row_d = rd_row_q;  b0_last_d = rd_last_q;
            end else begin
                b1_valid_d = 1'b1;  b1_data_d = push_data;  b1_row_d = rd_row_q;  b1_last_d = rd_last_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        remain_d   = remain_q;
        flip_d     = flip_q;
        busy_d     = busy_q;
        reject_d   = 1'b0;
        done_d     = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = addr_q;
        rd_valid_d = 1'b0;
        rd_row_d   = rd_row_q;
        rd_last_d  = rd_last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (illegal) begin
                        reject_d = 1'b1;
                    end else if (row_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = RUN;
                        busy_d   = 1'b1;
                        remain_d = row_count;
                        flip_d   = flip_v;
                        addr_d   = flip_v ? end_addr : first_row;
                    end
                end
            end
            RUN: begin
                if (space) begin
                    rd_en      = 1'b1;
                    rd_valid_d = 1'b1;
                    rd_row_d   = addr_q;
                    rd_last_d  = (remain_q == (AW+1)'(1));
                    remain_d   = remain_q - (AW+1)'(1);
                    if (flip_q) addr_d = (addr_q == '0) ? AW'(DEPTH-1) : addr_q - AW'(1);
                    else        addr_d = (addr_q == AW'(DEPTH-1)) ? '0 : addr_q + AW'(1);
                    if (remain_q == (AW+1)'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && b0_last_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            flip_q     <= 1'b0;
            busy_q     <= 1'b0;
            reject_q   <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_row_q   <= '0;
            rd_last_q  <= 1'b0;
            b0_valid_q <= 1'b0;  b0_data_q <= '0;  b0_row_q <= '0;  b0_last_q <= 1'b0;
            b1_valid_q <= 1'b0;  b1_data_q <= '0;  b1_row_q <= '0;  b1_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            remain_q   <= remain_d;
            flip_q     <= flip_d;
            busy_q     <= busy_d;
            reject_q   <= reject_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_row_q   <= rd_row_d;
            rd_last_q  <= rd_last_d;
            b0_valid_q <= b0_valid_d;  b0_data_q <= b0_data_d;  b0_row_q <= b0_row_d;  b0_last_q <= b0_last_d;
            b1_valid_q <= b1_valid_d;  b1_data_q <= b1_data_d;  b1_row_q <= b1_row_d;  b1_last_q <= b1_last_d;
        end
    end

    assign busy      = busy_q;
    assign reject    = reject_q;
    assign done      = done_q;
    assign out_valid = b0_valid_q;
    assign out_data  = b0_data_q;
    assign out_row   = b0_row_q;
    assign out_last  = b0_last_q;

endmodule

// File: tb/tb_sprite_row_streamer.sv
// Directed self-checking bench for sprite_row_streamer (default and SPRITE_HMIRROR_EN builds).
module tb_sprite_row_streamer;

    localparam int W = 51;
    localparam int D = 60;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         wr_en = 1'b0;
    logic [5:0]   wr_addr = '0;
    logic [W-1:0] wr_data = '0;
    logic         start = 1'b0;
    logic [5:0]   first_row = '0;
    logic [6:0]   row_count = '0;
    logic         flip_v = 1'b0;
    logic         mirror_h = 1'b0;
    logic         out_ready = 1'b1;
    logic         busy, reject, done, out_valid, out_last;
    logic [W-1:0] out_data;
    logic [5:0]   out_row;

    logic [W-1:0] mem_m [D];
    int n_checks = 0;
    int n_fail   = 0;

    sprite_row_streamer #(.WIDTH(W), .DEPTH(D), .AW(6)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .first_row(first_row), .row_count(row_count), .flip_v(flip_v),
        .mirror_h(mirror_h), .busy(busy), .reject(reject), .done(done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_row(out_row), .out_last(out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pat(input int r);
        logic [5:0]  r6;
        logic [53:0] t;
        r6 = 6'(r);
        t  = {9{r6}};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] exp_data(input int row, input bit mir);
        logic [W-1:0] d;
        logic [W-1:0] r;
        d = mem_m[row];
        r = d;
`ifdef SPRITE_HMIRROR_EN
        if (mir) for (int i = 0; i < W; i++) r[i] = d[W-1-i];
`else
        if (mir) r = d;
`endif
        return r;
    endfunction

    task automatic wr(input int a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
        step();
        wr_en = 1'b0;
        if (a < D) mem_m[a] = d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   busy,      0);
        check({tag, "_reject"}, reject,    0);
        check({tag, "_done"},   done,      0);
        check({tag, "_valid"},  out_valid, 0);
        check({tag, "_data"},   out_data,  0);
        check({tag, "_row"},    out_row,   0);
        check({tag, "_last"},   out_last,  0);
    endtask

    // mode 0: out_ready held high; mode 1: out_ready pattern 1,0,0 repeating.
    task automatic stream(input int first, input int count, input bit flip, input bit mir,
                          input int mode, input int abort, input bit poke);
        int k, got, lat, last_edge, er;
        bit prev_stall, fin;
        logic [W-1:0] pd;
        logic [5:0]   pr;
        logic         pl;
        first_row = 6'(first); row_count = 7'(count); flip_v = flip; mirror_h = mir; start = 1'b1;
        step();
        start = 1'b0; first_row = '0; row_count = '0; flip_v = 1'b0; mirror_h = 1'b0;
        check("busy_on", busy, 1);
        k = 0; got = 0; lat = -1; last_edge = -1; prev_stall = 0; fin = 0;
        pd = '0; pr = '0; pl = 1'b0;
        while (!fin && k < 400) begin
            if (poke && k == 3) begin
                start = 1'b1; first_row = 6'd5; row_count = 7'd2;
            end else begin
                start = 1'b0;
            end
            out_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
            if (lat < 0 && out_valid) begin
                lat = k;
                if (mode == 0) check("first_valid_latency", lat, 2);
            end
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data",  out_data,  pd);
                check("stall_row",   out_row,   pr);
                check("stall_last",  out_last,  pl);
            end
            if (out_valid && out_ready) begin
                er = flip ? ((first + count - 1 - got) % D) : ((first + got) % D);
                check("beat_row",  out_row,  er);
                check("beat_data", out_data, exp_data(er, mir));
                check("beat_last", out_last, (got == count - 1));
                got++;
                if (got == count) begin
                    fin = 1;
                    last_edge = k + 1;
                end
            end
            prev_stall = out_valid && !out_ready;
            pd = out_data; pr = out_row; pl = out_last;
            step();
            k++;
            if (abort > 0 && got == abort && !fin) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("abort");
                start = 1'b0; out_ready = 1'b1;
                step();
                rst_n = 1'b1;
                return;
            end
        end
        start = 1'b0; out_ready = 1'b1;
        if (!fin) begin
            check("stream_timeout_beats", got, count);
        end else begin
            if (mode == 0) check("last_accept_edge", last_edge, count + 2);
            check("done_pulse",  done,      1);
            check("busy_off",    busy,      0);
            check("valid_off",   out_valid, 0);
            step();
            check("done_clear",  done,      0);
            check("stays_idle",  busy,      0);
        end
    endtask

    initial begin
        for (int i = 0; i < D; i++) mem_m[i] = '0;

        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();
        check_all_zero("post_reset");

        for (int r = 0; r < D; r++) wr(r, pat(r));

        // Full range, forward, free-flowing consumer.
        stream(0, 60, 1'b0, 1'b0, 0, 0, 1'b0);

        // Flipped range wrapping through row 0: rows 1,0,59,58.
        stream(58, 4, 1'b1, 1'b0, 0, 0, 1'b0);

        // Stalling consumer plus an ignored start while busy.
        stream(10, 5, 1'b0, 1'b0, 1, 0, 1'b1);

        // Illegal starts.
        first_row = 6'd60; row_count = 7'd1; start = 1'b1;
        step();
        start = 1'b0;
        check("rej_row_pulse", reject, 1);
        check("rej_row_busy",  busy,   0);
        step();
        check("rej_row_clear", reject, 0);
        check("rej_row_idle",  busy,   0);

        first_row = 6'd0; row_count = 7'd61; start = 1'b1;
        step();
        start = 1'b0;
        check("rej_cnt_pulse", reject, 1);
        check("rej_cnt_busy",  busy,   0);
        step();
        check("rej_cnt_clear", reject, 0);

        // Zero-length stream.
        first_row = 6'd3; row_count = 7'd0; start = 1'b1;
        step();
        start = 1'b0;
        check("zero_done",   done,      1);
        check("zero_busy",   busy,      0);
        check("zero_reject", reject,    0);
        step();
        check("zero_done_clr", done,      0);
        check("zero_novalid",  out_valid, 0);

        // Abort mid-stream, then confirm memory survived reset.
        stream(0, 20, 1'b0, 1'b0, 0, 3, 1'b0);
        check_all_zero("after_abort");
        stream(17, 5, 1'b0, 1'b0, 0, 0, 1'b0);

        // Mirror: row holding 51'h1.
        wr(7, 51'h1);
`ifdef SPRITE_HMIRROR_EN
        check("mirror_model", exp_data(7, 1'b1), {1'b1, 50'h0});
`else
        check("mirror_model", exp_data(7, 1'b1), 51'h1);
`endif
        stream(7, 1, 1'b0, 1'b1, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
